// File: rtl/pcileech_com_pkg.sv
// Shared types and constants for the com TX/RX dword packers.
// Holds the TX FSM state type and the magic resync dword.
package pcileech_com_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MAGIC,
      HI,
      LO
   } com_tx_state_t;

   // Default preamble dword; the RX side compares against the same value.
   localparam logic [31:0] COM_MAGIC_DW = 32'h66665555;

   // Widths of the preamble dword counter (MAGIC_CNT <= 15)
   // and of the idle-gap counter (IDLE_GAP <= 255).
   localparam int COM_MCNT_W = 4;
   localparam int COM_IDLE_W = 8;

endpackage

// File: rtl/pcileech_com_tx64to32.sv
// pcileech_com_tx64to32: splits 64-bit core words into 32-bit dwords for the
// com TX FIFO, high dword [63:32] first, then [31:0].
//
// Optional feature macro: COM_TX_MAGIC_PREAMBLE_EN. When defined, a burst that
// starts after IDLE_GAP idle cycles is preceded by MAGIC_CNT copies of MAGIC.
//
// Ports:
//   clk          in   com clock, all logic on posedge
//   rst          in   synchronous active-high reset
//   din          in   64-bit core word
//   din_valid    in   din holds a word
//   din_ready    out  word accepted when din_valid & din_ready
//   dout         out  32-bit dword towards the TX FIFO, stable until accepted
//   dout_valid   out  dout holds a dword
//   dout_ready   in   sink can take a dword
//   busy         out  FSM not idle
//   tx_dw_count  out  data dwords sent (magic dwords excluded), wraps
module pcileech_com_tx64to32
   import pcileech_com_pkg::*;
#(
   parameter logic [31:0] MAGIC     = COM_MAGIC_DW,
   parameter int          MAGIC_CNT = 5,
   parameter int          IDLE_GAP  = 16,
   parameter int          CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [63:0]      din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic [31:0]      dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             busy,
   output logic [CNT_W-1:0] tx_dw_count
);

`ifdef COM_TX_MAGIC_PREAMBLE_EN
   // Whole word is kept: the high dword is sent after the preamble.
   localparam int HOLD_W = 64;

   localparam logic [COM_MCNT_W-1:0] LP_MAGIC_CNT =
      COM_MCNT_W'(MAGIC_CNT);
   localparam logic [COM_IDLE_W-1:0] LP_IDLE_GAP =
      COM_IDLE_W'(IDLE_GAP);
`else
   // High dword goes out straight from din; only the low half is kept.
   localparam int HOLD_W = 32;
`endif

   com_tx_state_t     r_state;
   com_tx_state_t     w_state_nx;
   logic [31:0]       r_dout;
   logic [31:0]       w_dout_nx;
   logic              r_dout_valid;
   logic              w_dout_valid_nx;
   logic [HOLD_W-1:0] r_hold;
   logic [HOLD_W-1:0] w_hold_nx;
   logic [CNT_W-1:0]  r_tx_cnt;
   logic [CNT_W-1:0]  w_tx_cnt_nx;
   logic              w_xfer;
   logic              w_din_hs;

`ifdef COM_TX_MAGIC_PREAMBLE_EN
   logic [COM_MCNT_W-1:0] r_mcnt;
   logic [COM_MCNT_W-1:0] w_mcnt_nx;
   logic [COM_IDLE_W-1:0] r_idle_cnt;
   logic [COM_IDLE_W-1:0] w_idle_nx;
`else
   logic w_unused_cfg;
   assign w_unused_cfg = ^{MAGIC, MAGIC_CNT, IDLE_GAP};
`endif

   assign w_xfer = r_dout_valid & dout_ready;

   // Accept in IDLE, or in LO exactly when the low dword leaves,
   // which gives back-to-back words with no bubble.
   assign din_ready = ~rst &
                      ((r_state == IDLE) |
                       ((r_state == LO) & w_xfer));

   assign w_din_hs = din_valid & din_ready;

   assign dout        = r_dout;
   assign dout_valid  = r_dout_valid;
   assign busy        = (r_state != IDLE);
   assign tx_dw_count = r_tx_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
         r_hold       <= '0;
         r_tx_cnt     <= '0;
      end else begin
         r_state      <= w_state_nx;
         r_dout       <= w_dout_nx;
         r_dout_valid <= w_dout_valid_nx;
         r_hold       <= w_hold_nx;
         r_tx_cnt     <= w_tx_cnt_nx;
      end
   end

`ifdef COM_TX_MAGIC_PREAMBLE_EN
   // Idle counter resets to IDLE_GAP so the first burst after reset
   // always carries a preamble.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcnt     <= '0;
         r_idle_cnt <= LP_IDLE_GAP;
      end else begin
         r_mcnt     <= w_mcnt_nx;
         r_idle_cnt <= w_idle_nx;
      end
   end
`endif

   always_comb begin
      w_state_nx      = r_state;
      w_dout_nx       = r_dout;
      w_dout_valid_nx = r_dout_valid;
      w_hold_nx       = r_hold;
      w_tx_cnt_nx     = r_tx_cnt;
`ifdef COM_TX_MAGIC_PREAMBLE_EN
      w_mcnt_nx       = r_mcnt;
      w_idle_nx       = r_idle_cnt;

      if ((r_state == IDLE) && !w_din_hs &&
          (r_idle_cnt != LP_IDLE_GAP)) begin
         w_idle_nx = r_idle_cnt + COM_IDLE_W'(1);
      end
`endif

      if (w_din_hs) begin
         w_hold_nx = din[HOLD_W-1:0];
      end

      unique case (r_state)
         IDLE: begin
            if (w_din_hs) begin
               w_dout_valid_nx = 1'b1;
               w_state_nx      = HI;
               w_dout_nx       = din[63:32];
`ifdef COM_TX_MAGIC_PREAMBLE_EN
               if (r_idle_cnt == LP_IDLE_GAP) begin
                  w_state_nx = pcileech_com_pkg::MAGIC;
                  w_dout_nx  = MAGIC;
                  w_mcnt_nx  = COM_MCNT_W'(1);
               end
`endif
            end
         end

`ifdef COM_TX_MAGIC_PREAMBLE_EN
         pcileech_com_pkg::MAGIC: begin
            if (w_xfer) begin
               if (r_mcnt < LP_MAGIC_CNT) begin
                  w_dout_nx = MAGIC;
                  w_mcnt_nx = r_mcnt + COM_MCNT_W'(1);
               end else begin
                  w_state_nx = HI;
                  w_dout_nx  = r_hold[63:32];
               end
            end
         end
`endif

         HI: begin
            if (w_xfer) begin
               w_state_nx  = LO;
               w_dout_nx   = r_hold[31:0];
               w_tx_cnt_nx = r_tx_cnt + CNT_W'(1);
            end
         end

         LO: begin
            if (w_xfer) begin
               w_tx_cnt_nx = r_tx_cnt + CNT_W'(1);
               if (w_din_hs) begin
                  w_state_nx = HI;
                  w_dout_nx  = din[63:32];
               end else begin
                  w_state_nx      = IDLE;
                  w_dout_valid_nx = 1'b0;
`ifdef COM_TX_MAGIC_PREAMBLE_EN
                  w_idle_nx       = '0;
`endif
               end
            end
         end

         default: begin
            w_state_nx      = IDLE;
            w_dout_valid_nx = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_pcileech_com_tx64to32.sv
// Bench for pcileech_com_tx64to32: vector table, directed corner cases and
// random traffic against a dword-queue reference model.
module tb_pcileech_com_tx64to32;

`ifdef COM_TX_MAGIC_PREAMBLE_EN
   localparam bit PRE = 1'b1;
`else
   localparam bit PRE = 1'b0;
`endif
   localparam logic [31:0] MW   = 32'h66665555;
   localparam int          MCNT = 5;
   localparam int          GAP  = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] din;
   logic        din_valid;
   logic        din_ready;
   logic [31:0] dout;
   logic        dout_valid;
   logic        dout_ready;
   logic        busy;
   logic [31:0] tx_dw_count;

   always #5 clk = ~clk;

   pcileech_com_tx64to32 dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .din_valid   (din_valid),
      .din_ready   (din_ready),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .dout_ready  (dout_ready),
      .busy        (busy),
      .tx_dw_count (tx_dw_count)
   );

   typedef struct {
      logic [31:0] dw;
      bit          data;
      bit          lo;
   } item_t;

   typedef struct {
      bit          v;
      logic [63:0] d;
      bit          rdy;
      bit          ev;
      logic [31:0] edout;
      logic [31:0] ecnt;
   } vec_t;

   // Model: dwords still owed to the sink, in order.
   item_t       q[$];
   logic [31:0] m_cnt;
   int          cyc;
   int          t_end;

   // Log of dwords the DUT actually handed over.
   logic [31:0] a_dw[$];
   int          a_cyc[$];

   logic [31:0] s_dout;
   logic [31:0] s_cnt;
   bit          s_valid;
   bit          s_hs;

   int chk_n;
   int pass_n;

   task automatic check(input string nm,
                        input logic [63:0] act,
                        input logic [63:0] exp);
      chk_n++;
      if (act === exp) pass_n++;
      else $display("FAIL %s: actual %0h required %0h (cycle %0d)",
                    nm, act, exp, cyc);
   endtask

   // One clock: drive at negedge, check outputs, then advance model
   // by what happens at the following posedge.
   task automatic step(input bit r, input bit v,
                       input logic [63:0] d, input bit rdy);
      bit    xfer;
      bit    hs;
      bit    b2b;
      item_t it;
      @(negedge clk);
      rst        = r;
      din_valid  = v;
      din        = d;
      dout_ready = rdy;
      #1;
      s_dout  = dout;
      s_valid = dout_valid;
      s_cnt   = tx_dw_count;
      s_hs    = 1'b0;
      if (r) begin
         q.delete();
         m_cnt = '0;
         t_end = cyc - 1000;
      end else begin
         check("dout_valid", dout_valid, q.size() != 0);
         check("busy", busy, q.size() != 0);
         check("din_ready", din_ready,
               (q.size() == 0) || (q.size() == 1 && rdy));
         if (q.size() != 0) check("dout", dout, q[0].dw);
         check("tx_dw_count", tx_dw_count, m_cnt);
         if (dout_valid && rdy) begin
            a_dw.push_back(dout);
            a_cyc.push_back(cyc);
         end
         xfer = (q.size() != 0) && rdy;
         hs   = v && ((q.size() == 0) || (q.size() == 1 && rdy));
         b2b  = 1'b0;
         if (xfer) begin
            it = q.pop_front();
            if (it.data) m_cnt++;
            if (it.lo) begin
               if (hs) b2b = 1'b1;
               else t_end = cyc;
            end
         end
         if (hs) begin
            if (PRE && !b2b && (cyc - t_end - 1) >= GAP)
               repeat (MCNT) q.push_back('{MW, 1'b0, 1'b0});
            q.push_back('{d[63:32], 1'b1, 1'b0});
            q.push_back('{d[31:0], 1'b1, 1'b1});
         end
         s_hs = hs;
      end
      cyc++;
   endtask

   task automatic offer(input logic [63:0] w);
      for (int i = 0; i < 40; i++) begin
         step(1'b0, 1'b1, w, 1'b1);
         if (s_hs) break;
      end
      check("din_accept", s_hs, 1'b1);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 64'h0, 1'b1);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && q.size() != 0; i++)
         step(1'b0, 1'b0, 64'h0, 1'b1);
   endtask

   vec_t        tv[12];
   logic [63:0] w0;
   logic [63:0] wa;
   logic [63:0] wb;
   logic [63:0] ws;
   logic [31:0] exp_l[$];
   logic [31:0] c0;
   int          base;
   int          npre;

   initial begin
      rst        = 1'b1;
      din_valid  = 1'b0;
      din        = '0;
      dout_ready = 1'b0;
      cyc        = 0;
      t_end      = -1000;
      m_cnt      = '0;
      chk_n      = 0;
      pass_n     = 0;
      npre       = PRE ? MCNT : 0;

      step(1'b1, 1'b0, 64'h0, 1'b0);
      step(1'b1, 1'b0, 64'h0, 1'b0);

      // Single word straight out of reset.
      w0 = 64'h11223344_55667788;
      for (int i = 0; i < 12; i++) begin
         tv[i] = '{(i == 0), w0, 1'b1, 1'b0, 32'h0, 32'h0};
         if (i >= 1 && i <= npre) begin
            tv[i].ev    = 1'b1;
            tv[i].edout = MW;
         end else if (i == npre + 1) begin
            tv[i].ev    = 1'b1;
            tv[i].edout = w0[63:32];
         end else if (i == npre + 2) begin
            tv[i].ev    = 1'b1;
            tv[i].edout = w0[31:0];
            tv[i].ecnt  = 32'd1;
         end else if (i > npre + 2) begin
            tv[i].ecnt  = 32'd2;
         end
      end
      for (int i = 0; i < 12; i++) begin
         step(1'b0, tv[i].v, tv[i].d, tv[i].rdy);
         check("tbl_valid", s_valid, tv[i].ev);
         if (tv[i].ev) check("tbl_dout", s_dout, tv[i].edout);
         check("tbl_cnt", s_cnt, tv[i].ecnt);
      end

      // Back-to-back A,B after a long idle: one preamble, 4 dwords.
      idle(20);
      wa   = 64'hA1A1A1A1_A2A2A2A2;
      wb   = 64'hB1B1B1B1_B2B2B2B2;
      base = a_dw.size();
      offer(wa);
      offer(wb);
      drain();
      exp_l.delete();
      repeat (npre) exp_l.push_back(MW);
      exp_l.push_back(wa[63:32]);
      exp_l.push_back(wa[31:0]);
      exp_l.push_back(wb[63:32]);
      exp_l.push_back(wb[31:0]);
      check("b2b_len", a_dw.size() - base, exp_l.size());
      if (a_dw.size() - base == exp_l.size()) begin
         foreach (exp_l[i]) check("b2b_dw", a_dw[base + i], exp_l[i]);
         check("b2b_span",
               a_cyc[base + npre + 3] - a_cyc[base + npre], 3);
      end

      // Stall 3 cycles while the high dword is presented.
      ws = 64'hC0DEC0DE_5EED5EED;
      offer(ws);
      for (int i = 0; i < 20; i++) begin
         if (q.size() == 2) break;
         step(1'b0, 1'b0, 64'h0, 1'b1);
      end
      c0 = m_cnt;
      repeat (3) begin
         step(1'b0, 1'b0, 64'h0, 1'b0);
         check("stall_dout", s_dout, ws[63:32]);
         check("stall_valid", s_valid, 1'b1);
         check("stall_cnt", s_cnt, c0);
      end
      drain();
      check("stall_hi", a_dw[a_dw.size() - 2], ws[63:32]);
      check("stall_lo", a_dw[a_dw.size() - 1], ws[31:0]);

      // Short idle: no preamble. Long idle: preamble again.
      idle(5);
      offer(64'h0102030405060708);
      step(1'b0, 1'b0, 64'h0, 1'b1);
      check("short_idle_dout", s_dout, 32'h01020304);
      drain();
      idle(16);
      offer(64'h1112131415161718);
      step(1'b0, 1'b0, 64'h0, 1'b1);
      check("long_idle_dout", s_dout, PRE ? MW : 32'h11121314);
      drain();

      // Reset while the low dword is pending.
      idle(3);
      offer(64'hDEADBEEF_CAFEF00D);
      for (int i = 0; i < 20; i++) begin
         if (q.size() == 1) break;
         step(1'b0, 1'b0, 64'h0, 1'b1);
      end
      step(1'b1, 1'b0, 64'h0, 1'b1);
      step(1'b0, 1'b0, 64'h0, 1'b1);
      check("rst_valid", s_valid, 1'b0);
      check("rst_cnt", s_cnt, 32'h0);
      offer(64'h99887766_55443322);
      step(1'b0, 1'b0, 64'h0, 1'b1);
      check("rst_pre_dout", s_dout, PRE ? MW : 32'h99887766);
      drain();

      // Random traffic with idle stretches and one reset.
      for (int i = 0; i < 3000; i++) begin
         bit v;
         bit r;
         if ((i % 400) < 24) v = 1'b0;
         else v = ($urandom % 3) != 0;
         r = (i == 1500);
         step(r, v, {$urandom, $urandom}, ($urandom % 4) != 0);
      end
      drain();
      idle(2);

      $display("%0d/%0d checks passed", pass_n, chk_n);
      $finish;
   end

endmodule
